// File: rtl/mod_addsub_seq_if.sv
// Request/response bundle for the limb-serial modular adder/subtractor.
interface mod_addsub_seq_if #(
  parameter int unsigned LIMBS = 4,
  parameter int unsigned W     = 64
);
  logic                 start;
  logic                 op;
  logic [LIMBS*W-1:0]   a;
  logic [LIMBS*W-1:0]   b;
  logic [LIMBS*W-1:0]   p;
  logic                 busy;
  logic                 done;
  logic [LIMBS*W-1:0]   result;

  modport master (output start, op, a, b, p, input busy, done, result);
  modport slave  (input start, op, a, b, p, output busy, done, result);
endinterface

// File: rtl/mod_addsub_seq.sv
// Limb-serial (a +/- b) mod p: one W-bit adder and one W-bit subtractor are
// shared across a raw pass (s = a +/- b) and a correction pass (t = s -/+ p).
module mod_addsub_seq #(
  parameter int unsigned LIMBS = 4,
  parameter int unsigned W     = 64
) (
  input  logic              clk,
  input  logic              rst,
  mod_addsub_seq_if.slave   bus
);
  localparam int unsigned CW = (LIMBS > 1) ? $clog2(LIMBS) : 1;

  typedef enum logic [1:0] {IDLE, PASS1, PASS2, FIN} state_t;
  typedef logic [LIMBS-1:0][W-1:0] vec_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          c_q, c_d;
  logic          f1_q, f1_d;
  logic          op_q, op_d;
  vec_t          a_q, a_d, b_q, b_d, p_q, p_d;
  vec_t          s_q, s_d, t_q, t_d, res_q, res_d;

  logic          last_limb;
  logic          use_sub;
  logic [W-1:0]  x_limb, y_limb;
  logic [W:0]    add_r, sub_r, limb_r;

  // Shared limb datapath: PASS1 works on (a, b), PASS2 on (s, p) with the
  // opposite primitive; bit W of limb_r is the carry/borrow out.
  always_comb begin
    last_limb = (cnt_q == CW'(LIMBS - 1));
    use_sub   = (state_q == PASS1) ? op_q : ~op_q;
    x_limb    = (state_q == PASS1) ? a_q[cnt_q] : s_q[cnt_q];
    y_limb    = (state_q == PASS1) ? b_q[cnt_q] : p_q[cnt_q];
    add_r     = {1'b0, x_limb} + {1'b0, y_limb} + {{W{1'b0}}, c_q};
    sub_r     = {1'b0, x_limb} - {1'b0, y_limb} - {{W{1'b0}}, c_q};
    limb_r    = use_sub ? sub_r : add_r;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      f1_q    <= 1'b0;
      op_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      s_q     <= '0;
      t_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      f1_q    <= f1_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      s_q     <= s_d;
      t_q     <= t_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    f1_d    = f1_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    s_d     = s_q;
    t_d     = t_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d    = bus.op;
          a_d     = bus.a;
          b_d     = bus.b;
          p_d     = bus.p;
          cnt_d   = '0;
          c_d     = 1'b0;
          state_d = PASS1;
        end
      end
      PASS1: begin
        s_d[cnt_q] = limb_r[W-1:0];
        c_d        = limb_r[W];
        cnt_d      = cnt_q + CW'(1);
        if (last_limb) begin
          f1_d    = limb_r[W];
          c_d     = 1'b0;
          cnt_d   = '0;
          state_d = PASS2;
        end
      end
      PASS2: begin
        t_d[cnt_q] = limb_r[W-1:0];
        c_d        = limb_r[W];
        cnt_d      = cnt_q + CW'(1);
        if (last_limb) begin
          c_d     = 1'b0;
          cnt_d   = '0;
          // The final flag of this pass (f2) is consumed directly here, so the
          // selected result is registered on entry to FIN and valid with done.
          if (op_q ? f1_q : (f1_q | ~limb_r[W]))
            res_d = t_d;
          else
            res_d = s_q;
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy   = (state_q != IDLE);
    bus.done   = (state_q == FIN);
    bus.result = res_q;
  end
endmodule

// File: doc/mod_addsub_seq.md
Name: mod_addsub_seq

Overview:
- Limb-serial modular adder/subtractor for prime-field elements in the ECC scalar-multiplication datapath.
- Sits directly upstream of the 64-bit add/sub primitives. It sequences them limb by limb with carry/borrow propagation, then performs the conditional modular correction.
- Consumed by the point add/double controller as its field add/sub unit.

Parameters:
- LIMBS, 4, number of 64-bit limbs per operand. Field width is LIMBS*64. Limb 0 is least significant.
- W, 64, limb width. Fixed to match the 64-bit add/sub primitives; other values are unsupported.

Ports:
- clk  input  1  clock. All state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse. Sampled only in IDLE.
- op  input  1  0 = (a+b) mod p; 1 = (a-b) mod p. Latched on start.
- a  input  LIMBS*W  operand A. Latched on start. Must satisfy a < p.
- b  input  LIMBS*W  operand B. Latched on start. Must satisfy b < p.
- p  input  LIMBS*W  modulus. Latched on start. Must be odd and > 2.
- busy  output  1  high from the cycle after start is accepted through the done cycle.
- done  output  1  single-cycle pulse; result is valid in this cycle.
- result  output  LIMBS*W  modular result. Holds its value until the next done.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, busy=0, done=0, result=0, limb counter=0, carry/borrow flag=0, all latched operands cleared. Reset mid-operation aborts the operation with no done pulse.
- States: IDLE, PASS1, PASS2, FIN.
- IDLE: when start=1, latch op/a/b/p, clear counter and flag, go to PASS1. start=0: stay.
- PASS1 (LIMBS cycles, counter i=0..LIMBS-1):
  - op=0: s[i] = a[i] + b[i] + c, c = carry-out.
  - op=1: s[i] = a[i] - b[i] - c, c = borrow-out.
  - c starts at 0.
  - At i=LIMBS-1: save the final flag as f1, clear c and counter, go to PASS2.
- PASS2 (LIMBS cycles):
  - op=0: t[i] = s[i] - p[i] - c (borrow chain).
  - op=1: t[i] = s[i] + p[i] + c (carry chain).
  - At i=LIMBS-1: save the final flag as f2, go to FIN.
- FIN (1 cycle): select the result, assert done=1, go to IDLE.
  - op=0: result = t if (f1==1 or f2==0), else s. This covers a+b == p giving 0, and overflow past 2^(LIMBS*W).
  - op=1: result = t if f1==1 (a<b), else s. f2 is ignored.
- Arithmetic per limb is exactly W-bit with a 1-bit carry/borrow. Exactly one adder and one subtractor primitive of width W are used. No full-width adder.
- Latency: start sampled at edge T gives done=1 in cycle T+2*LIMBS+1 (9 cycles for LIMBS=4). Back-to-back: the next start is accepted in the IDLE cycle following done. Throughput is one op per 2*LIMBS+2 cycles.
- busy is 1 in PASS1, PASS2 and FIN; 0 in IDLE.
- done is 0 in every state except FIN.
- start while busy=1 is ignored: no queuing, no effect on the running op.
- a, b, p and op changing while busy have no effect.
- Out-of-range inputs (a>=p or b>=p) produce an unspecified but deterministic result and must not hang the FSM.
- The carry/borrow flag is cleared between passes. No carry leaks across passes or across operations.

Test Plan:
Use p = 2^256 - 2^32 - 977 and LIMBS=4.
1. op=0, a=5, b=7 -> result=12; done exactly 9 cycles after the start edge; busy high for 9 cycles; done high for 1 cycle.
2. op=0 wrap cases:
   - a=p-1, b=2 -> result=1.
   - a=p-3, b=3 -> result=0 (a+b equals p).
   - a=p-1, b=p-1 -> result=p-2 (carry out of bit 255, f1=1).
3. op=1 cases:
   - a=3, b=5 -> result=p-2.
   - a=p-1, b=p-1 -> result=0.
   - a=2^64, b=1 -> result=0x...0000_FFFFFFFFFFFFFFFF (borrow crosses limb 0 into limb 1).
4. Back-to-back: issue the next start in the IDLE cycle after done -> both results correct, second done 10 cycles after the first. Pulse start during busy with different operands -> ignored; first result unaffected; no extra done.
5. Assert rst for one cycle while in PASS2 -> next cycle busy=0, done=0, result=0; no done follows. A subsequent op=0, a=1, b=1 -> result=2 in 9 cycles.
6. Random regression: 1000 random a,b < p, random op; compare against a reference (a±b) mod p computed at full width; no mismatches, done latency always 9.
